bus_read_master: RTL and testbench
==================================

BUS_READ_MASTER -- requirements
Module: bus_read_master

Interface
REQ-001 Parameter: ADDR_W, default 8, bus address width.
REQ-002 Parameter: DATA_W, default 16, bus data width.
REQ-003 Parameter: TIMEOUT_CYCLES, default 16, maximum cycles ds stays asserted waiting for da; legal range 2..255.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  read request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_addr  input  ADDR_W  address to read.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  consumer accepts response.
REQ-011 rsp_data  output  DATA_W  read data.
REQ-012 rsp_err  output  1  transaction timed out.
REQ-013 as  output  1  address strobe to bus manager.
REQ-014 rw  output  1  1 = read; driven 1 only while as is high, else 0.
REQ-015 ds  output  1  data strobe to bus manager.
REQ-016 addr  output  ADDR_W  bus address.
REQ-017 da  input  1  data acknowledge from bus manager.
REQ-018 data  input  DATA_W  bus read data, valid when da=1.

Function
REQ-019 FSM states: IDLE, ADDR, DATA, RESP, RELEASE; all outputs registered.
REQ-020 IDLE: req_ready=1 only when da=0; on req_valid&&req_ready latch req_addr, go to ADDR.
REQ-021 ADDR (exactly 1 cycle): as=1, rw=1, addr=latched address, ds=0; go to DATA.
REQ-022 DATA: as=1, ds=1; timeout counter increments each cycle from 0.
REQ-023 DATA with da=1 sampled: capture data into rsp_data, rsp_err=0, go to RESP.
REQ-024 DATA with counter == TIMEOUT_CYCLES-1 and da=0: rsp_data=0, rsp_err=1, go to RESP.
REQ-025 If da=1 on the timeout cycle, the data capture (REQ-023) wins and rsp_err=0.
REQ-026 RESP: as=ds=rw=0, rsp_valid=1; rsp_data/rsp_err held stable until rsp_ready=1.
REQ-027 RESP with rsp_ready=1: go to IDLE if da=0, else RELEASE.
REQ-028 RELEASE: all strobes 0, req_ready=0; remain until da=0, then go to IDLE.
REQ-029 Minimum latency: request accepted at cycle 0, as high at cycle 1, ds high at cycle 2, rsp_valid high at cycle 3 when da=1 at cycle 2.
REQ-030 Throughput: at most one outstanding transaction; req_ready=0 in every state except IDLE.
REQ-031 addr holds the latched value from ADDR through DATA and returns to 0 in all other states.
REQ-032 A da pulse arriving in IDLE or ADDR is ignored and does not affect the next transaction.

Reset
REQ-033 When rst=0, the block shall asynchronously force IDLE; as, ds, rw, addr, rsp_valid, rsp_data, rsp_err and the timeout counter shall go to 0.
REQ-034 Reset asserted mid-transaction shall discard captured data; no response shall be produced for the aborted request.
REQ-035 Reset deassertion shall be synchronous to clk; req_ready shall become 1 on the first cycle after release if da=0.

Structure
REQ-036 A shared package bus_pkg shall hold the state enum, the ADDR_W/DATA_W defaults and the TIMEOUT_CYCLES default.
REQ-037 The timeout counter shall be the sub-module bus_timeout_cnt (clear/enable/expired, parameterised width).
REQ-038 The bus-side ports shall match the busreader view of the existing bus interface so the block connects directly to it.

Verification
REQ-039 Read addr 0x3C, manager asserts da with data 0xBEEF at the first ds cycle -> rsp_valid at cycle 3, rsp_data=0xBEEF, rsp_err=0.
REQ-040 Manager delays da by 5 cycles after ds -> ds held 6 cycles, then correct data returned, rsp_err=0.
REQ-041 Manager never asserts da, TIMEOUT_CYCLES=16 -> ds high exactly 16 cycles, then rsp_err=1, rsp_data=0x0000.
REQ-042 rsp_ready held 0 for 4 cycles while da stays high -> rsp_valid and rsp_data stable; after acceptance, FSM waits in RELEASE and req_ready rises only once da=0.
REQ-043 rst pulled low during DATA -> as, ds, rsp_valid go to 0 immediately; no response is issued; after release a new read to 0xFF completes normally.
REQ-044 Back-to-back requests with rsp_ready=1 -> second as rises no earlier than 1 cycle after the first response is accepted with da=0, and addr changes from the first address to the second.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and defaults for the bus read master and its timeout counter.
package bus_pkg;

  localparam int unsigned BusAddrW         = 8;
  localparam int unsigned BusDataW         = 16;
  localparam int unsigned BusTimeoutCycles = 16;
  // Wide enough for the largest legal timeout (255).
  localparam int unsigned TimeoutCntW      = 8;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StResp,
    StRelease
  } bus_state_e;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Saturating up-counter that flags when the data phase has run for Limit+1 cycles.
module bus_timeout_cnt #(
  parameter int unsigned Width = 8,
  parameter int unsigned Limit = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == Width'(Limit));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_read_master.sv
// Single-outstanding read master: address phase, data phase with timeout, then a held
// response; waits for the manager to drop da before accepting the next request.
module bus_read_master
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W         = BusAddrW,
  parameter int unsigned DATA_W         = BusDataW,
  parameter int unsigned TIMEOUT_CYCLES = BusTimeoutCycles
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              as_o,
  output logic              rw_o,
  output logic              ds_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic              da_i,
  input  logic [DATA_W-1:0] data_i
);

  bus_state_e state_q, state_d;

  logic              as_q, as_d;
  logic              rw_q, rw_d;
  logic              ds_q, ds_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              tmo_expired;

  bus_timeout_cnt #(
    .Width (TimeoutCntW),
    .Limit (TIMEOUT_CYCLES - 1)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (state_q == StAddr),
    .en_i      (state_q == StData),
    .expired_o (tmo_expired)
  );

  // A lingering da from the previous transaction must not be mistaken for a new ack.
  assign req_ready_o = (state_q == StIdle) && !da_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (req_valid_i && req_ready_o) state_d = StAddr;
      StAddr:    state_d = StData;
      StData:    if (da_i || tmo_expired) state_d = StResp;
      StResp:    if (rsp_ready_i) state_d = da_i ? StRelease : StIdle;
      StRelease: if (!da_i) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs are derived from the next state so that every output is a flop.
  always_comb begin
    as_d        = 1'b0;
    ds_d        = 1'b0;
    addr_d      = '0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_d)
      StAddr: begin
        as_d   = 1'b1;
        addr_d = req_addr_i;
      end
      StData: begin
        as_d   = 1'b1;
        ds_d   = 1'b1;
        addr_d = addr_q;
      end
      StResp:  rsp_valid_d = 1'b1;
      default: ;
    endcase
    // Capture beats timeout when da arrives on the last allowed cycle.
    if (state_q == StData && state_d == StResp) begin
      rsp_data_d = da_i ? data_i : '0;
      rsp_err_d  = !da_i;
    end
    rw_d = as_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      as_q        <= 1'b0;
      rw_q        <= 1'b0;
      ds_q        <= 1'b0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      as_q        <= as_d;
      rw_q        <= rw_d;
      ds_q        <= ds_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign as_o        = as_q;
  assign rw_o        = rw_q;
  assign ds_o        = ds_q;
  assign addr_o      = addr_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_bus_read_master.sv
// Randomised bench for bus_read_master: a behavioural bus manager plus per-transaction
// expectations computed from ack delay, response stall and da hold time.
module tb_bus_read_master;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 16;
  localparam int unsigned TMO = 16;

  logic          clk;
  logic          rst_ni;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          as_s;
  logic          rw_s;
  logic          ds_s;
  logic [AW-1:0] addr_s;
  logic          da;
  logic [DW-1:0] data;

  int n_checks = 0;
  int n_errors = 0;

  bus_read_master #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .as_o        (as_s),
    .rw_o        (rw_s),
    .ds_o        (ds_s),
    .addr_o      (addr_s),
    .da_i        (da),
    .data_i      (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One read. delay: data cycles before da (>= TMO means never); stall: cycles rsp_ready
  // is held low; hold: cycles da stays high after acceptance; addr_da: spurious da in ADDR.
  task automatic do_read(input logic [AW-1:0] a, input int delay, input logic [DW-1:0] d,
                         input int stall, input int hold, input logic addr_da);
    bit            got;
    int            exp_ds;
    logic [DW-1:0] exp_data;
    int            ds_cnt;
    bit            left_data;
    got      = (delay < TMO);
    exp_ds   = got ? delay + 1 : TMO;
    exp_data = got ? d : '0;

    // Cycle 0: request offered and accepted.
    @(negedge clk);
    da        = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    #1 chk("idle_req_ready", req_ready, 1);

    // Cycle 1: address phase.
    @(negedge clk);
    chk("addr_as", as_s, 1);
    chk("addr_rw", rw_s, 1);
    chk("addr_ds", ds_s, 0);
    chk("addr_addr", addr_s, a);
    chk("addr_req_ready", req_ready, 0);
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    da        = addr_da;
    data      = DW'($urandom);

    // Data phase.
    ds_cnt    = 0;
    left_data = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!ds_s) begin
        left_data = 1'b1;
        break;
      end
      ds_cnt++;
      chk("data_as", as_s, 1);
      chk("data_addr", addr_s, a);
      chk("data_rsp_valid", rsp_valid, 0);
      da   = got && (ds_cnt == delay + 1);
      data = da ? d : DW'($urandom);
    end
    chk("data_phase_ended", left_data, 1);
    chk("ds_cycles", ds_cnt, exp_ds);

    // Response phase, held until accepted.
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) @(negedge clk);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, exp_data);
      chk("rsp_err", rsp_err, !got);
      chk("rsp_strobes", {as_s, ds_s, rw_s}, 0);
      chk("rsp_addr", addr_s, 0);
      chk("rsp_req_ready", req_ready, 0);
      da        = (s == stall) ? (hold > 0) : got;
      data      = DW'($urandom);
      rsp_ready = (s == stall);
    end

    // Release: idle again only once da has dropped.
    for (int i = 1; i <= hold + 1; i++) begin
      @(negedge clk);
      chk("rel_rsp_valid", rsp_valid, 0);
      chk("rel_strobes", {as_s, ds_s, rw_s}, 0);
      chk("rel_addr", addr_s, 0);
      rsp_ready = 1'b0;
      da        = (i < hold);
      #1 chk("rel_req_ready", req_ready, (i == hold + 1));
    end
  endtask

  initial begin
    rst_ni    = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    da        = 1'b0;
    data      = '0;

    #2;
    chk("rst_strobes", {as_s, ds_s, rw_s}, 0);
    chk("rst_addr", addr_s, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);

    @(negedge clk);
    rst_ni = 1'b1;
    #1 chk("post_rst_req_ready", req_ready, 1);

    // Directed: minimal latency, delayed ack, timeout, ack on timeout cycle, stalled rsp.
    do_read(8'h3C, 0, 16'hBEEF, 0, 0, 1'b0);
    do_read(8'h12, 5, 16'h1234, 0, 0, 1'b0);
    do_read(8'hA5, 255, 16'hDEAD, 0, 0, 1'b0);
    do_read(8'h5A, TMO - 1, 16'hCAFE, 0, 0, 1'b0);
    do_read(8'h77, TMO - 2, 16'h0F0F, 1, 0, 1'b1);
    do_read(8'h81, 2, 16'hA1B2, 4, 3, 1'b0);

    // Spurious da in idle is ignored.
    @(negedge clk);
    da = 1'b1;
    #1 chk("idle_da_req_ready", req_ready, 0);
    do_read(8'h42, 1, 16'h5555, 0, 1, 1'b1);

    // Reset in the middle of the data phase.
    @(negedge clk);
    da        = 1'b0;
    req_valid = 1'b1;
    req_addr  = 8'h99;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_ds", ds_s, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_strobes", {as_s, ds_s, rw_s}, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_addr", addr_s, 0);
    chk("mid_rst_rsp_data", rsp_data, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    #1 chk("mid_rst_req_ready", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("aborted_no_rsp", rsp_valid, 0);
      chk("aborted_no_as", as_s, 0);
    end
    do_read(8'hFF, 3, 16'h6789, 0, 0, 1'b0);

    // Randomised transactions.
    for (int t = 0; t < 40; t++) begin
      int dly;
      dly = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, TMO + 1));
      do_read(AW'($urandom), dly, DW'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
